// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command/register-file slave: frame FSM states and
// command byte layout {rw, addr[6:0]}.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_e;

    localparam int CMD_W  = 8;
    localparam int RW_BIT = 7;
    localparam int ADDR_W = 7;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin with rise/fall pulses taken from
// the last two synchroniser stages.
module spi_edge_sync
    import spi_cmd_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    // Bit 0 is the newest sample; higher indices are older.
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    assign o_fall = ~r_sync[SYNC_STAGES-2] & r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_cmd_regfile.sv
// SPI mode-0 slave: a command byte {rw, addr} followed by DATA_W data bits writes or reads
// back one of NUM_REGS registers. All SPI pins are oversampled in the clk domain.
module spi_cmd_regfile
    import spi_cmd_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                NUM_REGS    = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spi_sclk,
    input  logic                         spi_cs_n,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    output logic                         spi_miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_done,
    output logic                         frame_err
);

    localparam int CNT_W = $clog2(DATA_W + CMD_W) + 1;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(CMD_W + DATA_W - 1);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic w_mosi, w_rw, w_addr_ok;
    logic [ADDR_W-1:0] w_addr;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rx_word;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    state_e                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [CMD_W-1:0]       r_cmd;
    logic [DATA_W-2:0]      r_rx;
    logic [DATA_W-2:0]      r_tx;
    logic                   r_tx_loaded;
    logic                   r_miso;
    logic                   r_miso_oe;
    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wr_strobe;
    logic                   r_frame_done;
    logic                   r_frame_err;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_async (spi_sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_async (spi_cs_n),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rw      = r_cmd[RW_BIT];
    assign w_addr    = r_cmd[ADDR_W-1:0];
    assign w_idx     = w_addr[IDX_W-1:0];
    assign w_addr_ok = (int'(w_addr) < NUM_REGS);
    assign w_rx_word = {r_rx, w_mosi};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_cmd        <= '0;
            r_rx         <= '0;
            r_tx         <= '0;
            r_tx_loaded  <= 1'b0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_wr_strobe  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RESET_VAL;
            end
        end else begin
            r_wr_strobe  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_cs_fall) begin
                r_miso_oe <= 1'b1;
            end else if (w_cs_rise) begin
                r_miso_oe <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state     <= CMD;
                        r_tx_loaded <= 1'b0;
                        r_miso      <= 1'b0;
                        // A rising SCLK seen with the select edge is the first command bit.
                        if (w_sclk_rise) begin
                            r_bit_cnt <= CNT_W'(1);
                            r_cmd     <= {r_cmd[CMD_W-2:0], w_mosi};
                        end else begin
                            r_bit_cnt <= '0;
                        end
                    end
                end
                CMD: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_cmd     <= {r_cmd[CMD_W-2:0], w_mosi};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_CMD) begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                        r_miso      <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_rx      <= w_rx_word[DATA_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_DATA) begin
                            r_state <= DONE;
                            r_miso  <= 1'b0;
                            if (!w_addr_ok) begin
                                r_frame_err <= 1'b1;
                            end else begin
                                r_frame_done <= 1'b1;
                                if (!w_rw) begin
                                    r_regs[w_idx]      <= w_rx_word;
                                    r_wr_strobe[w_idx] <= 1'b1;
                                end
                            end
                        end
                    end else if (w_sclk_fall) begin
                        // First falling edge of the data phase loads the readback word.
                        if (!r_tx_loaded) begin
                            r_tx_loaded <= 1'b1;
                            if (w_rw && w_addr_ok) begin
                                r_tx   <= r_regs[w_idx][DATA_W-2:0];
                                r_miso <= r_regs[w_idx][DATA_W-1];
                            end else begin
                                r_tx   <= '0;
                                r_miso <= 1'b0;
                            end
                        end else begin
                            r_miso <= r_tx[DATA_W-2];
                            r_tx   <= r_tx << 1;
                        end
                    end
                end
                DONE: begin
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_o[k*DATA_W +: DATA_W] = r_regs[k];
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign wr_strobe   = r_wr_strobe;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Self-checking bench for spi_cmd_regfile: directed frames plus randomised frames against
// an array model of the register file and per-frame pulse counts.
`timescale 1ns/1ps
module tb_spi_cmd_regfile;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int HALF     = 50;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       spi_sclk, spi_cs_n, spi_mosi;
    logic                       spi_miso, spi_miso_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_o;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       frame_done, frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]          model [NUM_REGS];
    int                  n_done, n_err, n_strb;
    logic [NUM_REGS-1:0] strb_mask;

    spi_cmd_regfile #(
        .DATA_W      (DATA_W),
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (2),
        .RESET_VAL   ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .regs_o      (regs_o),
        .wr_strobe   (wr_strobe),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_done = n_done + 1;
        if (frame_err)  n_err  = n_err + 1;
        n_strb    = n_strb + $countones(wr_strobe);
        strb_mask = strb_mask | wr_strobe;
    end

    function automatic logic [NUM_REGS*DATA_W-1:0] model_pack();
        logic [NUM_REGS*DATA_W-1:0] p;
        for (int k = 0; k < NUM_REGS; k++) p[k*DATA_W +: DATA_W] = model[k];
        return p;
    endfunction

    // Host side of one frame: bits are sent MSB first from bits[23]; MISO sampled on rises.
    task automatic spi_frame(input logic [23:0] bits, input int nbits, input bit raise_cs,
                             output logic [7:0] rd, output logic [7:0] cmd_miso,
                             output logic oe_mid);
        rd       = '0;
        cmd_miso = '0;
        spi_mosi = bits[23];
        spi_cs_n = 1'b0;
        #HALF;
        oe_mid = spi_miso_oe;
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b1;
            if (i < 8) cmd_miso[7-i] = spi_miso;
            else if (i < 16) rd[15-i] = spi_miso;
            #HALF;
            spi_sclk = 1'b0;
            spi_mosi = (i < 23) ? bits[22-i] : 1'b0;
            #HALF;
        end
        if (raise_cs) begin
            spi_cs_n = 1'b1;
            #(4*HALF);
        end
    endtask

    task automatic clear_counts();
        n_done = 0; n_err = 0; n_strb = 0; strb_mask = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (regs_o !== model_pack()) begin
            n_fail++; $display("FAIL reset_regs: got %h expected %h", regs_o, model_pack());
        end
        n_tests++;
        if ({wr_strobe, frame_done, frame_err, spi_miso, spi_miso_oe} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {wr_strobe, frame_done, frame_err, spi_miso, spi_miso_oe});
        end
        reset = 1'b0;
        #(4*HALF);
    endtask

    task automatic test_write_read();
        logic [7:0] rd, cm; logic oe;
        clear_counts();
        spi_frame({8'h02, 8'hA5, 8'h00}, 16, 1'b1, rd, cm, oe);
        model[2] = 8'hA5;
        n_tests++;
        if (regs_o[23:16] !== 8'hA5) begin
            n_fail++; $display("FAIL write_reg2: got %h expected a5", regs_o[23:16]);
        end
        n_tests++;
        if (strb_mask !== 4'b0100 || n_strb !== 1 || n_done !== 1 || n_err !== 0) begin
            n_fail++;
            $display("FAIL write_pulses: got mask=%b strb=%0d done=%0d err=%0d expected 0100/1/1/0",
                     strb_mask, n_strb, n_done, n_err);
        end
        n_tests++;
        if (oe !== 1'b1) begin
            n_fail++; $display("FAIL miso_oe_mid: got %b expected 1", oe);
        end
        clear_counts();
        spi_frame({8'h82, 8'h3C, 8'h00}, 16, 1'b1, rd, cm, oe);
        n_tests++;
        if (rd !== 8'hA5) begin
            n_fail++; $display("FAIL read_reg2: got %h expected a5", rd);
        end
        n_tests++;
        if (cm !== 8'h00) begin
            n_fail++; $display("FAIL miso_cmd_phase: got %h expected 00", cm);
        end
        n_tests++;
        if (regs_o !== model_pack() || n_done !== 1 || n_strb !== 0) begin
            n_fail++;
            $display("FAIL read_side_effects: got regs=%h done=%0d strb=%0d expected %h/1/0",
                     regs_o, n_done, n_strb, model_pack());
        end
    endtask

    task automatic test_bad_addr();
        logic [7:0] rd, cm; logic oe;
        clear_counts();
        spi_frame({8'h09, 8'h3C, 8'h00}, 16, 1'b1, rd, cm, oe);
        n_tests++;
        if (regs_o !== model_pack() || n_strb !== 0 || n_err !== 1 || n_done !== 0) begin
            n_fail++;
            $display("FAIL bad_write: got regs=%h strb=%0d err=%0d done=%0d expected %h/0/1/0",
                     regs_o, n_strb, n_err, n_done, model_pack());
        end
        clear_counts();
        spi_frame({8'h89, 8'h00, 8'h00}, 16, 1'b1, rd, cm, oe);
        n_tests++;
        if (rd !== 8'h00 || n_err !== 1 || n_done !== 0) begin
            n_fail++;
            $display("FAIL bad_read: got rd=%h err=%0d done=%0d expected 00/1/0", rd, n_err, n_done);
        end
    endtask

    task automatic test_abort();
        logic [7:0] rd, cm; logic oe;
        clear_counts();
        spi_frame({8'h01, 8'hF0, 8'h00}, 12, 1'b1, rd, cm, oe);
        n_tests++;
        if (regs_o !== model_pack() || n_err !== 1 || n_done !== 0 || n_strb !== 0) begin
            n_fail++;
            $display("FAIL abort: got regs=%h err=%0d done=%0d strb=%0d expected %h/1/0/0",
                     regs_o, n_err, n_done, n_strb, model_pack());
        end
        clear_counts();
        spi_frame({8'h01, 8'h6B, 8'h00}, 16, 1'b1, rd, cm, oe);
        model[1] = 8'h6B;
        n_tests++;
        if (regs_o !== model_pack() || n_done !== 1 || n_err !== 0) begin
            n_fail++;
            $display("FAIL after_abort: got regs=%h done=%0d err=%0d expected %h/1/0",
                     regs_o, n_done, n_err, model_pack());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rd, cm; logic oe;
        spi_frame({8'h03, 8'h5A, 8'h00}, 12, 1'b0, rd, cm, oe);
        reset = 1'b1;
        #20;
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
        n_tests++;
        if (regs_o !== model_pack() || spi_miso_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got regs=%h oe=%b expected %h/0",
                     regs_o, spi_miso_oe, model_pack());
        end
        spi_cs_n = 1'b1; spi_sclk = 1'b0;
        #HALF;
        reset = 1'b0;
        #(2*HALF);
        clear_counts();
        spi_frame({8'h00, 8'h77, 8'h00}, 16, 1'b1, rd, cm, oe);
        model[0] = 8'h77;
        n_tests++;
        if (regs_o !== model_pack() || n_done !== 1 || strb_mask !== 4'b0001) begin
            n_fail++;
            $display("FAIL after_reset: got regs=%h done=%0d mask=%b expected %h/1/0001",
                     regs_o, n_done, strb_mask, model_pack());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd, cm; logic oe;
        clear_counts();
        spi_frame({8'h00, 8'h11, 8'h00}, 16, 1'b1, rd, cm, oe);
        spi_frame({8'h03, 8'hFF, 8'h00}, 16, 1'b1, rd, cm, oe);
        model[0] = 8'h11; model[3] = 8'hFF;
        n_tests++;
        if (regs_o !== model_pack() || n_done !== 2 || n_strb !== 2 || strb_mask !== 4'b1001) begin
            n_fail++;
            $display("FAIL back_to_back: got regs=%h done=%0d strb=%0d mask=%b expected %h/2/2/1001",
                     regs_o, n_done, n_strb, strb_mask, model_pack());
        end
    endtask

    task automatic test_extra_clocks();
        logic [7:0] rd, cm; logic oe;
        clear_counts();
        spi_frame({8'h01, 8'hC3, 8'hFF}, 24, 1'b1, rd, cm, oe);
        model[1] = 8'hC3;
        n_tests++;
        if (regs_o !== model_pack() || n_done !== 1 || n_strb !== 1 || n_err !== 0) begin
            n_fail++;
            $display("FAIL extra_clocks: got regs=%h done=%0d strb=%0d err=%0d expected %h/1/1/0",
                     regs_o, n_done, n_strb, n_err, model_pack());
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, cm, data; logic oe;
        int addr, nbits, exp_done, exp_err, exp_strb;
        bit rw, abort;
        for (int it = 0; it < 24; it++) begin
            addr  = $urandom_range(0, 9);
            rw    = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            abort = ($urandom_range(0, 4) == 0);
            nbits = abort ? $urandom_range(1, 15) : 16;
            clear_counts();
            spi_frame({rw, 7'(addr), data, 8'h00}, nbits, 1'b1, rd, cm, oe);
            exp_done = 0; exp_err = 0; exp_strb = 0;
            if (abort || addr >= NUM_REGS) begin
                exp_err = 1;
            end else begin
                exp_done = 1;
                if (!rw) begin
                    model[addr] = data;
                    exp_strb    = 1;
                end
            end
            n_tests++;
            if (regs_o !== model_pack() || n_done !== exp_done || n_err !== exp_err ||
                n_strb !== exp_strb) begin
                n_fail++;
                $display("FAIL random_%0d: got regs=%h done=%0d err=%0d strb=%0d expected %h/%0d/%0d/%0d",
                         it, regs_o, n_done, n_err, n_strb, model_pack(), exp_done, exp_err, exp_strb);
            end
            if (rw && !abort) begin
                n_tests++;
                if (rd !== ((addr < NUM_REGS) ? model[addr] : 8'h00)) begin
                    n_fail++;
                    $display("FAIL random_read_%0d: got %h expected %h", it, rd,
                             (addr < NUM_REGS) ? model[addr] : 8'h00);
                end
            end
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_write_read();
        test_bad_addr();
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
        test_extra_clocks();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
